// File: rtl/nec_ir_tx.sv
// NEC infrared frame transmitter: builds the mark/space envelope from a tick
// time base and gates the 37.9 kHz carrier onto the LED drive.
module nec_ir_tx #(
   parameter int TICK_CYCLES = 28125
) (
   input  logic       clk_50,
   input  logic       reset,
   input  logic       clk_38,
   input  logic       start,
   input  logic       rpt,
   input  logic [7:0] addr,
   input  logic [7:0] cmd,
   output logic       busy,
   output logic       done,
   output logic       envelope,
   output logic       ir_out
);

   localparam int PW = $clog2(TICK_CYCLES);
   localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEAD, S_LSPACE, S_BMARK, S_BSPACE, S_STOP
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [PW-1:0]   r_pre;
   logic [4:0]      r_seg;
   logic [4:0]      r_bit;
   logic [31:0]     r_sh;
   logic            r_rpt;
   logic            r_env;
   logic            r_done;
   logic            w_accept;
   logic            w_tick;
   logic            w_seg_end;
   logic [4:0]      w_dur_m1;
   logic            w_env_nxt;
   logic            w_done_nxt;

   assign w_accept  = (r_state == S_IDLE) && start;
   assign w_tick    = (r_state != S_IDLE) && (r_pre == PMAX);
   assign w_seg_end = w_tick && (r_seg == w_dur_m1);

   // Last segment-count value of each state; bit spaces stretch to 3 ticks for a 1.
   always_comb begin
      w_dur_m1 = 5'd0;
      case (r_state)
         S_LEAD:   w_dur_m1 = 5'd15;
         S_LSPACE: w_dur_m1 = r_rpt ? 5'd3 : 5'd7;
         S_BSPACE: w_dur_m1 = r_sh[0] ? 5'd2 : 5'd0;
         default:  w_dur_m1 = 5'd0;
      endcase
   end

   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start)     w_next = S_LEAD;
         S_LEAD:   if (w_seg_end) w_next = S_LSPACE;
         S_LSPACE: if (w_seg_end) w_next = r_rpt ? S_STOP : S_BMARK;
         S_BMARK:  if (w_seg_end) w_next = S_BSPACE;
         S_BSPACE: if (w_seg_end) w_next = (r_bit == 5'd31) ? S_STOP : S_BMARK;
         S_STOP:   if (w_seg_end) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_env_nxt  = (w_next == S_LEAD) || (w_next == S_BMARK) || (w_next == S_STOP);
      w_done_nxt = (r_state == S_STOP) && (w_next == S_IDLE);
   end

   // Prescaler restarts on acceptance so every segment is an exact tick multiple.
   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         r_pre  <= '0;
         r_seg  <= 5'd0;
         r_bit  <= 5'd0;
         r_env  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_env  <= w_env_nxt;
         r_done <= w_done_nxt;
         if (w_accept)                r_pre <= '0;
         else if (w_tick)             r_pre <= '0;
         else if (r_state != S_IDLE)  r_pre <= r_pre + PW'(1);
         if (r_state != w_next)       r_seg <= 5'd0;
         else if (w_tick)             r_seg <= r_seg + 5'd1;
         if (w_accept)                r_bit <= 5'd0;
         else if ((r_state == S_BSPACE) && w_seg_end) r_bit <= r_bit + 5'd1;
      end
   end

   // Frame payload: bit 0 of the shift register is always the bit being sent.
   always_ff @(posedge clk_50) begin
      if (w_accept) begin
         r_sh  <= {~cmd, cmd, ~addr, addr};
         r_rpt <= rpt;
      end else if ((r_state == S_BSPACE) && w_seg_end) begin
         r_sh  <= {1'b0, r_sh[31:1]};
      end
   end

   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign envelope = r_env;
   assign ir_out   = r_env & clk_38;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Bench for nec_ir_tx: table of frames measured and decoded from the envelope,
// plus back-to-back, carrier gating and mid-frame reset sequences.
module tb_nec_ir_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clk_38 = 1'b0;
   logic       start = 1'b0;
   logic       rpt = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] cmd = 8'h00;
   logic       busy, done, envelope, ir_out;
   logic       start_b = 1'b0;
   logic       busy_b, done_b, env_b, ir_b;

   int checks = 0;
   int failures = 0;
   int gate_err = 0;
   int car_cnt = 0;

   nec_ir_tx #(.TICK_CYCLES(4)) dut (
      .clk_50(clk), .reset(reset), .clk_38(clk_38), .start(start), .rpt(rpt),
      .addr(addr), .cmd(cmd), .busy(busy), .done(done), .envelope(envelope),
      .ir_out(ir_out)
   );

   nec_ir_tx #(.TICK_CYCLES(28125)) dut_big (
      .clk_50(clk), .reset(reset), .clk_38(clk_38), .start(start_b), .rpt(1'b0),
      .addr(8'h12), .cmd(8'h34), .busy(busy_b), .done(done_b), .envelope(env_b),
      .ir_out(ir_b)
   );

   always #5 clk = ~clk;

   // Carrier: 1320-cycle period, 441 cycles high, synchronous to clk.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         car_cnt = (car_cnt == 1319) ? 0 : car_cnt + 1;
         clk_38  = (car_cnt < 441);
      end
   end

   always @(negedge clk) begin
      if (!reset)
         gate_err <= gate_err + int'(ir_out !== (envelope & clk_38));
   end

   typedef struct {
      logic        rpt;
      logic [7:0]  addr;
      logic [7:0]  cmd;
      logic        poke;
      int          exp_busy;
      int          exp_pulses;
      int          exp_high;
      int          exp_first;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   // Caller positions at a negedge; start is presented here and accepted on the next posedge.
   task automatic run_frame(input vec_t v, input string tag);
      int n, bc, hc, np, ns, run, dn, dcyc;
      logic prev;
      int pl[40];
      int sl[40];
      logic [31:0] word;
      rpt = v.rpt; addr = v.addr; cmd = v.cmd; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; addr = ~v.addr; cmd = ~v.cmd; rpt = ~v.rpt;
      n = 0; bc = 0; hc = 0; np = 0; ns = 0; run = 0; dn = 0; dcyc = 0; prev = 1'b0;
      for (int i = 0; i < 40; i++) begin pl[i] = 0; sl[i] = 0; end
      while (n < 2000 && dcyc == 0) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            chk({tag, "_lat_busy"}, int'(busy), 1);
            chk({tag, "_lat_env"}, int'(envelope), 1);
         end
         if (v.poke && n == 100) begin start = 1'b1; addr = 8'h5A; end
         if (v.poke && n == 101) start = 1'b0;
         if (busy) bc++;
         if (envelope) hc++;
         if (done) begin dcyc = n; dn++; end
         if (envelope != prev) begin
            if (prev) begin
               if (np < 40) pl[np] = run;
               np++;
            end else if (np > 0) begin
               if (ns < 40) sl[ns] = run;
               ns++;
            end
            run = 1;
         end else begin
            run++;
         end
         prev = envelope;
      end
      if (dcyc == 0) chk({tag, "_timeout"}, 0, 1);
      repeat (4) begin
         @(negedge clk);
         if (done) dn++;
      end
      word = '0;
      for (int i = 0; i < 32; i++) word[i] = (i + 1 < 40) && (sl[i+1] > 8);
      chk({tag, "_busy_cycles"}, bc, v.exp_busy);
      chk({tag, "_done_cycle"}, dcyc, v.exp_busy + 1);
      chk({tag, "_done_count"}, dn, 1);
      chk({tag, "_pulses"}, np, v.exp_pulses);
      chk({tag, "_high_cycles"}, hc, v.exp_high);
      chk({tag, "_first_pulse"}, pl[0], v.exp_first);
      if (v.rpt) begin
         chk({tag, "_rpt_space"}, sl[0], 16);
         chk({tag, "_rpt_stop"}, pl[1], 4);
      end else begin
         chk({tag, "_lead_space"}, sl[0], 32);
         chk({tag, "_word"}, int'(word), int'(v.exp_word));
      end
   endtask

   initial begin
      int n, dn, e0, e1, ones;

      vecs[0] = '{1'b0, 8'h04, 8'h08, 1'b0, 484, 34, 196, 64, 32'hF708FB04};
      vecs[1] = '{1'b1, 8'h77, 8'h99, 1'b0,  84,  2,  68, 64, 32'h0};
      vecs[2] = '{1'b0, 8'hA5, 8'h3C, 1'b1, 484, 34, 196, 64, 32'hC33C5AA5};
      vecs[3] = '{1'b0, 8'hFF, 8'h00, 1'b0, 484, 34, 196, 64, 32'hFF0000FF};

      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_env", int'(envelope), 0);
      chk("rst_ir", int'(ir_out), 0);
      reset = 1'b0;

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         run_frame(vecs[i], $sformatf("vec%0d", i));
      end

      // Start held high through the done cycle: second LEAD follows immediately.
      @(negedge clk);
      rpt = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      n = 0; dn = 0;
      while (n < 300 && dn == 0) begin
         @(negedge clk);
         n++;
         if (done) dn++;
      end
      chk("b2b_done1_cycle", n, 85);
      chk("b2b_busy_in_done", int'(busy), 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("b2b_lead_busy", int'(busy), 1);
      chk("b2b_lead_env", int'(envelope), 1);
      n = 1;
      while (n < 300 && dn < 2) begin
         @(negedge clk);
         n++;
         if (done) dn++;
      end
      repeat (4) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("b2b_done2_cycle", n, 85);
      chk("b2b_done_count", dn, 2);

      // Carrier gating at the real tick rate (only the lead mark fits in the run).
      e0 = 0; e1 = 0; ones = 0;
      repeat (1500) begin
         @(negedge clk);
         if (env_b !== 1'b0 || ir_b !== 1'b0) e0++;
      end
      start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      repeat (3000) begin
         @(negedge clk);
         if (env_b !== 1'b1 || ir_b !== clk_38) e1++;
         if (ir_b === 1'b1) ones++;
      end
      chk("carrier_idle_err", e0, 0);
      chk("carrier_mark_err", e1, 0);
      chk("carrier_active", int'(ones > 0), 1);
      chk("carrier_busy", int'(busy_b), 1);

      // Reset in the middle of the leader space.
      @(negedge clk);
      rpt = 1'b0; addr = 8'h04; cmd = 8'h08; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (80) @(negedge clk);
      chk("mid_busy", int'(busy), 1);
      chk("mid_env_space", int'(envelope), 0);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_env", int'(envelope), 0);
      chk("arst_ir", int'(ir_out), 0);
      chk("arst_done", int'(done), 0);
      dn = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("arst_no_done", dn, 0);
      reset = 1'b0;
      run_frame(vecs[0], "post_rst");

      chk("gate_err", gate_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nec_ir_tx.md
# nec_ir_tx

NEC-protocol infrared frame transmitter for the remote. It accepts an 8-bit address and an 8-bit command, or a repeat request, from the controller logic. It builds the NEC mark/space envelope and gates the 37.9 kHz, 1/3-duty carrier from `clk_38k` to produce the IR LED drive. It sits directly downstream of `clk_38k` and consumes its `clk_38` output.

## Interface
- `TICK_CYCLES`, default 28125: clk_50 cycles per NEC time unit of 562.5 µs. Must be ≥ 2; benches use 4.
- `clk_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `clk_38`  in  1  carrier from `clk_38k`, synchronous to `clk_50`.
- `start`  in  1  request a frame; sampled only while idle.
- `rpt`  in  1  qualifies `start`: 1 = send a repeat code, 0 = send a data frame.
- `addr`  in  8  address byte; sampled with `start`.
- `cmd`  in  8  command byte; sampled with `start`.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame end.
- `envelope`  out  1  registered mark (1) / space (0) envelope.
- `ir_out`  out  1  `envelope & clk_38`, combinational AND, to the LED driver.

## Operation
- Reset values: `busy`=0, `done`=0, `envelope`=0, so `ir_out`=0. All counters clear and the FSM goes to IDLE.
- Time base:
  - A prescaler counts 0..TICK_CYCLES-1. It is cleared when a frame is accepted.
  - Each wrap is one tick.
  - A segment counter counts ticks within the current state.
- Data frame:
  - Shift register loads {~cmd, cmd, ~addr, addr} and transmits bit 0 first.
  - So the bit order is addr LSB-first, then ~addr, then cmd, then ~cmd.
- FSM states and durations in ticks (envelope value in brackets):
  - IDLE [0].
  - LEAD [1]: 16 ticks.
  - LSPACE [0]: 8 ticks for a data frame, 4 ticks for a repeat code.
  - BIT_MARK [1]: 1 tick.
  - BIT_SPACE [0]: 1 tick for bit=0, 3 ticks for bit=1.
  - STOP [1]: 1 tick.
- Transitions:
  - IDLE→LEAD on `start`.
  - LEAD→LSPACE.
  - LSPACE→BIT_MARK for a data frame; LSPACE→STOP for a repeat code.
  - BIT_MARK→BIT_SPACE.
  - BIT_SPACE→BIT_MARK while bit index < 31; after bit 31, BIT_SPACE→STOP.
  - STOP→IDLE.
- Handshake:
  - `start` is accepted only in IDLE, i.e. while `busy`=0.
  - `start` while busy is ignored, not queued.
  - `addr`, `cmd` and `rpt` are latched on acceptance; later changes have no effect.
- Inter-frame gap (108 ms NEC period) is the controller's responsibility. This block does not enforce it.
- The carrier is not resynchronised: `ir_out` takes whatever phase `clk_38` has during marks.

## Timing
- Acceptance edge E:
  - At E+1, `busy`=1, `envelope`=1, and the state is LEAD.
  - Latency from `start` to first mark is 1 cycle.
- Segment boundaries:
  - Every `envelope` transition occurs exactly on a tick boundary.
  - Mark and space widths are exact multiples of TICK_CYCLES cycles, with zero jitter.
- Data frame:
  - 121 ticks total: 16 + 8 + 32 + 16·1 + 16·3 + 1.
  - `busy` is high for 121·TICK_CYCLES cycles.
  - `envelope` is high for 49·TICK_CYCLES cycles in 34 pulses.
- Repeat frame:
  - 21 ticks total.
  - `busy` is high for 21·TICK_CYCLES cycles.
  - `envelope` is high for 17·TICK_CYCLES cycles in 2 pulses.
- End of frame:
  - On the edge that leaves STOP, `envelope`→0, `busy`→0 and `done`→1, all in the same cycle.
  - `done` lasts exactly 1 cycle.
- Back-to-back: `start` asserted in the `done` cycle is accepted, and the next LEAD begins on the following cycle.
- Reset mid-frame:
  - Outputs go to reset values immediately (asynchronous); there is no `done` pulse.
  - After `reset` deasserts, the block is idle and accepts `start` on the first clock.

## Test plan
- TICK_CYCLES=4; data frame with `addr`=0x04, `cmd`=0x08 → `busy` high 484 cycles; 34 envelope pulses; first pulse 64 cycles; decoded spaces give bytes 0x04, 0xFB, 0x08, 0xF7; single `done`.
- Repeat frame (`start`=1, `rpt`=1, with arbitrary `addr`/`cmd`) → `busy` 84 cycles; envelope 64 cycles high, 16 low, 4 high; `done` at cycle 85.
- `start` pulsed again, with different `addr`, 100 cycles into a frame → ignored; frame content and length unchanged.
- Carrier gating: drive `clk_38` with the 1320-cycle, 441-high pattern and TICK_CYCLES=28125 → `ir_out` equals `clk_38` whenever `envelope`=1, and is never 1 when `envelope`=0.
- `reset` asserted mid-LSPACE → `envelope`, `ir_out` and `busy` go to 0 without waiting for a clock edge; no `done`; a new `start` after release produces a full, correct frame.
- `start` held high across the `done` cycle → second frame's LEAD begins on the cycle after `done`; two `done` pulses total.
